// File: rtl/lfsr_rand_gen_if.sv
// Request/response bundle between a game-logic consumer and the random source.
interface lfsr_rand_gen_if #(
  parameter int unsigned OUT_BITS = 3
) ();
  logic                req;
  logic [OUT_BITS-1:0] limit;
  logic                busy;
  logic                valid;
  logic [OUT_BITS-1:0] rand_out;
  logic                fallback;

  modport master (
    output req, limit,
    input  busy, valid, rand_out, fallback
  );

  modport slave (
    input  req, limit,
    output busy, valid, rand_out, fallback
  );
endinterface

// File: rtl/lfsr_rand_gen.sv
// XNOR Fibonacci LFSR that free-runs while idle and serves uniform values in [0, limit)
// through rejection sampling, with a fallback result after MAX_TRIES rejections.
module lfsr_rand_gen #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_BITS  = 3,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             seed_load_i,
  output logic [WIDTH-1:0] lfsr_state_o,
  lfsr_rand_gen_if.slave   bus
);

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_rand_gen: WIDTH must be 3..16");
  end
  if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
    $error("lfsr_rand_gen: OUT_BITS must be 1..WIDTH");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_max_tries
    $error("lfsr_rand_gen: MAX_TRIES must be 1..255");
  end

  // Maximal-length tap set per width; tap n maps to bit n-1.
  function automatic logic [WIDTH-1:0] tap_mask();
    logic [15:0] m;
    case (WIDTH)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m[WIDTH-1:0];
  endfunction

  localparam logic [WIDTH-1:0] Taps     = tap_mask();
  localparam int unsigned      CntW     = $clog2(OUT_BITS + 1);
  localparam logic [CntW-1:0]  LastShft = CntW'(OUT_BITS - 1);
  localparam logic [7:0]       MaxTries = 8'(MAX_TRIES);

  typedef enum logic [1:0] {StIdle, StShift, StCheck, StDone} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [OUT_BITS-1:0] limit_q, limit_d;
  logic [CntW-1:0]     shift_cnt_q, shift_cnt_d;
  logic [7:0]          tries_q, tries_d;
  logic                busy_q, busy_d;
  logic [OUT_BITS-1:0] rand_q, rand_d;
  logic                fallback_q, fallback_d;

  logic [WIDTH-1:0]    seed_clean;
  logic [WIDTH-1:0]    lfsr_step;
  logic [OUT_BITS-1:0] candidate;
  logic [7:0]          tries_inc;

  // All-ones is the XNOR lockup state, so it can never be loaded.
  assign seed_clean = (&seed_i) ? {seed_i[WIDTH-1:1], 1'b0} : seed_i;
  assign lfsr_step  = {lfsr_q[WIDTH-2:0], ~^(lfsr_q & Taps)};
  assign candidate  = lfsr_q[OUT_BITS-1:0];

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    limit_d     = limit_q;
    shift_cnt_d = shift_cnt_q;
    tries_d     = tries_q;
    busy_d      = busy_q;
    rand_d      = rand_q;
    fallback_d  = fallback_q;
    tries_inc   = tries_q + 8'd1;

    unique case (state_q)
      StIdle: begin
        if (seed_load_i) begin
          lfsr_d = seed_clean;
        end else begin
          lfsr_d = lfsr_step;
          if (bus.req) begin
            limit_d     = bus.limit;
            shift_cnt_d = '0;
            tries_d     = '0;
            busy_d      = 1'b1;
            state_d     = StShift;
          end
        end
      end
      StShift: begin
        lfsr_d      = lfsr_step;
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (shift_cnt_q == LastShft) state_d = StCheck;
      end
      StCheck: begin
        if (limit_q == '0 || candidate < limit_q) begin
          rand_d     = candidate;
          fallback_d = 1'b0;
          state_d    = StDone;
        end else begin
          tries_d = tries_inc;
          if (tries_inc == MaxTries) begin
            rand_d     = '0;
            fallback_d = 1'b1;
            state_d    = StDone;
          end else begin
            shift_cnt_d = '0;
            state_d     = StShift;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Recover from an upset into the lockup state regardless of FSM state.
    if (&lfsr_q) lfsr_d = seed_clean;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      lfsr_q      <= seed_clean;
      limit_q     <= '0;
      shift_cnt_q <= '0;
      tries_q     <= '0;
      busy_q      <= 1'b0;
      rand_q      <= '0;
      fallback_q  <= 1'b0;
    end else if (enable_i) begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      limit_q     <= limit_d;
      shift_cnt_q <= shift_cnt_d;
      tries_q     <= tries_d;
      busy_q      <= busy_d;
      rand_q      <= rand_d;
      fallback_q  <= fallback_d;
    end
  end

  assign lfsr_state_o = lfsr_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = (state_q == StDone);
  assign bus.rand_out = rand_q;
  assign bus.fallback = fallback_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Scoreboard bench: a transaction-level LFSR model predicts each response and the idle
// register contents; a negedge monitor compares whatever the DUT presents.
module tb_lfsr_rand_gen;
  localparam int W       = 3;
  localparam int OB      = 3;
  localparam int MAX     = 2;
  localparam int Mask3   = (1 << 2) | (1 << 1);
  localparam int Mask8   = (1 << 7) | (1 << 5) | (1 << 4) | (1 << 3);
  localparam int OutMask = (1 << OB) - 1;

  typedef struct {int due; int res; int fb;} resp_t;
  typedef struct {int at; int lfsr; int res; int fb;} snap_t;

  logic         clock = 1'b0;
  logic         reset, enable, seed_load;
  logic [W-1:0] seed;
  logic [W-1:0] lfsr3;
  logic         reset8;
  logic [7:0]   lfsr8;

  lfsr_rand_gen_if #(.OUT_BITS(OB)) bus3 ();
  lfsr_rand_gen_if #(.OUT_BITS(OB)) bus8 ();

  lfsr_rand_gen #(.WIDTH(W), .OUT_BITS(OB), .MAX_TRIES(MAX)) u_dut3 (
    .clock       (clock),
    .reset       (reset),
    .enable_i    (enable),
    .seed_i      (seed),
    .seed_load_i (seed_load),
    .lfsr_state_o(lfsr3),
    .bus         (bus3)
  );

  lfsr_rand_gen #(.WIDTH(8), .OUT_BITS(OB), .MAX_TRIES(8)) u_dut8 (
    .clock       (clock),
    .reset       (reset8),
    .enable_i    (1'b1),
    .seed_i      (8'h00),
    .seed_load_i (1'b0),
    .lfsr_state_o(lfsr8),
    .bus         (bus8)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int    n_checks = 0;
  int    n_pass   = 0;
  resp_t resp_q[$];
  snap_t snap_q[$];
  int    busy_from = 1;
  int    busy_to   = 0;
  bit    mon_on    = 1'b0;
  bit    valid_prev = 1'b0;
  bit    w8_done   = 1'b0;
  bit    seen[256];
  int    m, last_res, last_fb;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: one LFSR advance from the tap list rule (XNOR of taps shifted in at bit 0).
  function automatic int lfsr_next(input int s, input int w, input int mask);
    int fb;
    fb = ($countones(s & mask) % 2 == 0) ? 1 : 0;
    return ((s << 1) | fb) & ((1 << w) - 1);
  endfunction

  function automatic int sanitise(input int v, input int w);
    return (v == (1 << w) - 1) ? v - 1 : v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_snap();
    snap_t s;
    s = '{cyc, m, last_res, last_fb};
    snap_q.push_back(s);
  endtask

  task automatic idle_cycle(input bit en, input bit sl);
    enable     = en;
    seed_load  = sl;
    bus3.req   = 1'b0;
    bus3.limit = W'($urandom_range(0, 7));
    tick();
    if (en) m = sl ? sanitise(int'(seed), W) : lfsr_next(m, W, Mask3);
    push_snap();
  endtask

  task automatic do_reset(input int sd);
    seed      = W'(sd);
    reset     = 1'b0;
    enable    = 1'b1;
    seed_load = 1'b0;
    bus3.req  = 1'b0;
    tick();
    reset    = 1'b1;
    m        = sanitise(sd, W);
    last_res = 0;
    last_fb  = 0;
    push_snap();
  endtask

  // fmode: 0 no freeze, 1 freeze while shifting, 2 freeze while valid is up.
  task automatic do_req(input int lim, input int fmode, input int flen);
    int s, n, tries, res, fb, lat, c, fat, fl;
    bit done, frozen;
    resp_t r;
    s = lfsr_next(m, W, Mask3);
    n = 0; tries = 0; res = 0; fb = 0; done = 1'b0;
    while (!done) begin
      for (int k = 0; k < OB; k++) s = lfsr_next(s, W, Mask3);
      n++;
      if (lim == 0 || (s & OutMask) < lim) begin
        res = s & OutMask; fb = 0; done = 1'b1;
      end else begin
        tries++;
        if (tries == MAX) begin
          res = 0; fb = 1; done = 1'b1;
        end
      end
    end
    lat = 1 + n * (OB + 1);
    fl  = (fmode == 0) ? 0 : flen;
    fat = (fmode == 1) ? $urandom_range(1, 3) : lat;
    c   = cyc;
    busy_from = c + 1;
    busy_to   = c + lat + fl;
    r = '{c + lat + ((fmode == 1) ? fl : 0), res, fb};
    resp_q.push_back(r);
    bus3.req   = 1'b1;
    bus3.limit = W'(lim);
    enable     = 1'b1;
    seed_load  = 1'b0;
    tick();
    for (int i = 1; i <= lat + fl; i++) begin
      frozen     = (fl > 0) && (i >= fat) && (i < fat + fl);
      enable     = !frozen;
      bus3.req   = 1'($urandom_range(0, 1));
      seed_load  = 1'($urandom_range(0, 1));
      bus3.limit = W'($urandom_range(0, 7));
      tick();
    end
    bus3.req  = 1'b0;
    seed_load = 1'b0;
    enable    = 1'b1;
    m         = s;
    last_res  = res;
    last_fb   = fb;
    push_snap();
  endtask

  always @(negedge clock) begin : monitor
    resp_t r;
    snap_t s;
    if (mon_on) begin
      check("busy", int'(bus3.busy), int'(cyc >= busy_from && cyc <= busy_to));
      if (bus3.valid && !valid_prev) begin
        if (resp_q.size() == 0) begin
          check("stray valid", int'(bus3.valid), 0);
        end else begin
          r = resp_q.pop_front();
          check("valid cycle", cyc, r.due);
          check("rand_out", int'(bus3.rand_out), r.res);
          check("fallback", int'(bus3.fallback), r.fb);
        end
      end else if (resp_q.size() != 0 && cyc > resp_q[0].due) begin
        check("valid by deadline", int'(bus3.valid), 1);
        void'(resp_q.pop_front());
      end
      valid_prev = bus3.valid;
      if (snap_q.size() != 0 && snap_q[0].at == cyc) begin
        s = snap_q.pop_front();
        check("lfsr_state", int'(lfsr3), s.lfsr);
        check("held rand_out", int'(bus3.rand_out), s.res);
        check("held fallback", int'(bus3.fallback), s.fb);
      end
    end
  end

  initial begin : w8_freerun
    int s8, distinct;
    bus8.req   = 1'b0;
    bus8.limit = '0;
    reset8     = 1'b0;
    @(posedge clock);
    #1;
    reset8 = 1'b1;
    s8     = 0;
    check("w8 reset lfsr", int'(lfsr8), 0);
    check("w8 reset busy", int'(bus8.busy), 0);
    for (int i = 0; i < 255; i++) begin
      tick();
      s8 = lfsr_next(s8, 8, Mask8);
      check("w8 step", int'(lfsr8), s8);
      seen[lfsr8] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check("w8 distinct states", distinct, 255);
    check("w8 all-ones absent", int'(seen[255]), 0);
    check("w8 no valid", int'(bus8.valid), 0);
    check("w8 rand_out idle", int'(bus8.rand_out), 0);
    check("w8 fallback idle", int'(bus8.fallback), 0);
    w8_done = 1'b1;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int c, lim, fmode;
    reset = 1'b0; enable = 1'b1; seed_load = 1'b0; seed = '0;
    bus3.req = 1'b0; bus3.limit = '0;
    m = 0; last_res = 0; last_fb = 0;

    do_reset(0);
    mon_on = 1'b1;
    repeat (8) idle_cycle(1'b1, 1'b0);

    do_reset(0); do_req(0, 0, 0);
    do_reset(0); do_req(5, 0, 0);
    do_reset(1); do_req(1, 0, 0);
    do_reset(0); do_req(0, 1, 4);
    do_reset(2); do_req(0, 2, 3);

    // Reset mid-request aborts it without a strobe.
    do_reset(0);
    c = cyc;
    busy_from = c + 1;
    busy_to   = c + 2;
    bus3.req = 1'b1; bus3.limit = '0;
    tick();
    bus3.req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m = sanitise(int'(seed), W); last_res = 0; last_fb = 0;
    push_snap();
    repeat (12) idle_cycle(1'b1, 1'b0);

    do_reset(7);
    repeat (2) idle_cycle(1'b1, 1'b0);
    seed = 3'b111;
    idle_cycle(1'b1, 1'b1);
    idle_cycle(1'b0, 1'b0);

    // seed_load wins over a simultaneous req.
    seed = 3'b101; bus3.req = 1'b1; seed_load = 1'b1; enable = 1'b1;
    tick();
    bus3.req = 1'b0; seed_load = 1'b0;
    m = 5;
    push_snap();
    repeat (8) idle_cycle(1'b1, 1'b0);

    // Lockup recovery from an upset into all-ones.
    seed = 3'b010;
    tick();
    force u_dut3.lfsr_q = 3'b111;
    #1;
    release u_dut3.lfsr_q;
    tick();
    m = sanitise(int'(seed), W);
    push_snap();
    repeat (2) idle_cycle(1'b1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      for (int g = $urandom_range(0, 4); g > 0; g--) begin
        if ($urandom_range(0, 7) == 0) begin
          seed = W'($urandom_range(0, 7));
          idle_cycle(1'b1, 1'b1);
        end else begin
          idle_cycle(1'($urandom_range(0, 9) != 0), 1'b0);
        end
      end
      lim   = $urandom_range(0, 7);
      fmode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      do_req(lim, fmode, $urandom_range(1, 4));
    end

    for (int i = 0; i < 1000 && !w8_done; i++) @(posedge clock);
    check("w8 process finished", int'(w8_done), 1);
    repeat (3) idle_cycle(1'b1, 1'b0);
    check("responses drained", resp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
